// File: rtl/friscv_sv_pkg.sv
// Shared types and constants for the FRiscV UART boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package friscv_sv_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int LOADER_HDR_BYTES = 4;

  // Loader sequencing: header, size check, word assembly, write, final states
  typedef enum logic [2:0] {
    HDR,
    CHK,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  // Serial receiver phases
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/friscv_uart_rx.sv
// 8N1 UART receiver, LSB first, with 2-flop input synchroniser and start-glitch rejection.
// Latency: byte_valid_o pulses one cycle after the mid-stop-bit sample; line is 2 cycles late.
// Backpressure: none; the consumer must take each byte in its single valid cycle.
module friscv_uart_rx
  import friscv_sv_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam int HALF   = CLKS_PER_BIT / 2;

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("friscv_uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic                      sync1_q, sync2_q;
  rx_state_t                 state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [BIT_W-1:0]          bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      byte_valid_q, frame_err_q;

  // Two-flop synchroniser; only sync2_q is ever used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Receiver FSM: detect start, confirm at half bit, sample data and stop at bit centres
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!sync2_q) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A line that is high again at mid-start was only a glitch
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[UART_DATA_BITS-1:1]};
            if (bit_q == BIT_W'(UART_DATA_BITS - 1)) state_q <= RX_STOP;
            else                                      bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q        <= '0;
            byte_valid_q <= sync2_q;
            frame_err_q  <= !sync2_q;
            state_q      <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = shift_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/friscv_uart_loader.sv
// UART boot loader: header word count N then N little-endian words written to IMEM from address 0.
// Latency: IMEM write one cycle after the 4th byte of a word; release one cycle after last write.
// Backpressure: none; bytes arrive at line rate and the one-cycle write never collides with the next byte.
module friscv_uart_loader
  import friscv_sv_pkg::*;
#(
  parameter int ARCH             = 32,
  parameter int IMEM_ADDR_WIDTH  = 12,
  parameter int IMEM_DEPTH_BYTES = 4096,
  parameter int CLKS_PER_BIT     = 868
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx_in,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_out,
  output logic [ARCH-1:0]            imem_din_out,
  output logic                       imem_we_out,
  output logic                       core_rst_n_out,
  output logic                       load_done_out,
  output logic                       err_out
);

  localparam int MAX_WORDS = IMEM_DEPTH_BYTES / 4;

  if (ARCH != 32) begin : g_bad_arch
    $error("friscv_uart_loader: ARCH must be 32");
  end

  logic       rx_vld;
  logic [7:0] rx_dat;
  logic       rx_ferr;

  friscv_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (uart_rx_in),
    .byte_valid_o(rx_vld),
    .byte_o      (rx_dat),
    .frame_err_o (rx_ferr)
  );

  loader_state_t              state_q;
  logic [1:0]                 byte_idx_q;
  logic [31:0]                n_q;
  logic [31:0]                k_q;
  logic [31:0]                k_d;
  logic [ARCH-9:0]            word_q;   // lower three bytes of the word in flight
  logic [IMEM_ADDR_WIDTH-1:0] addr_q;
  logic [ARCH-1:0]            din_q;
  logic                       we_q, done_q, core_rst_n_q, err_q;

  assign k_d = k_q + 32'd1;

  // Loader FSM with registered IMEM write port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HDR;
      byte_idx_q   <= '0;
      n_q          <= '0;
      k_q          <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        HDR: begin
          if (rx_ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (rx_vld) begin
            // Bytes shift in from the top so the first byte ends up as the LSB
            n_q        <= {rx_dat, n_q[31:8]};
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'(LOADER_HDR_BYTES - 1)) state_q <= CHK;
          end
        end
        CHK: begin
          // Compare against the word capacity so N*4 can never overflow
          if (n_q == 32'd0) begin
            state_q      <= DONE;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
          end else if (n_q > 32'(MAX_WORDS)) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            state_q    <= DATA;
            k_q        <= '0;
            byte_idx_q <= '0;
          end
        end
        DATA: begin
          if (rx_ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (rx_vld) begin
            word_q     <= {rx_dat, word_q[ARCH-9:8]};
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'(LOADER_HDR_BYTES - 1)) begin
              state_q <= WRITE;
              we_q    <= 1'b1;
              addr_q  <= IMEM_ADDR_WIDTH'({k_q, 2'b00});
              din_q   <= {rx_dat, word_q};
            end
          end
        end
        WRITE: begin
          if (rx_ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            k_q <= k_d;
            if (k_d == n_q) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DONE: state_q <= DONE;
        ERR:  state_q <= ERR;
        default: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr_out  = addr_q;
  assign imem_din_out   = din_q;
  assign imem_we_out    = we_q;
  assign core_rst_n_out = core_rst_n_q;
  assign load_done_out  = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_friscv_uart_loader.sv
// Directed bench for the UART boot loader: serial images in, IMEM writes checked against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_friscv_uart_loader;

  localparam int CPB   = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx_in = 1'b1;
  logic [AW-1:0] imem_addr_out;
  logic [31:0]   imem_din_out;
  logic          imem_we_out;
  logic          core_rst_n_out;
  logic          load_done_out;
  logic          err_out;

  friscv_uart_loader #(
    .ARCH(32), .IMEM_ADDR_WIDTH(AW), .IMEM_DEPTH_BYTES(DEPTH), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx_in    (uart_rx_in),
    .imem_addr_out (imem_addr_out),
    .imem_din_out  (imem_din_out),
    .imem_we_out   (imem_we_out),
    .core_rst_n_out(core_rst_n_out),
    .load_done_out (load_done_out),
    .err_out       (err_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: expected IMEM writes in order, plus whether the release must follow a write
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] img[8];
  bit          exp_write_before_release = 1'b0;

  int          we_cycles = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we_out) begin
        we_cycles++;
        last_addr = 32'(imem_addr_out);
        last_data = imem_din_out;
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   imem_addr_out, imem_din_out);
        end else begin
          chk("write_addr", 32'(imem_addr_out), exp_addr_q.pop_front());
          chk("write_data", imem_din_out, exp_data_q.pop_front());
        end
      end
      chk("core_rst_follows_done", 32'(core_rst_n_out), 32'(load_done_out));
      if (err_out) chk("err_holds_core", 32'(core_rst_n_out), 32'd0);
      if (load_done_out && !prev_done)
        chk("release_after_last_write", 32'(prev_we), 32'(exp_write_before_release));
      prev_we   = imem_we_out;
      prev_done = load_done_out;
    end else begin
      prev_we   = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    uart_rx_in = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx_in = 1'b1;
  endtask

  // Header N, then the first nw words of img; data byte number 'bad' gets a low stop bit
  task automatic send_image(input logic [31:0] n, input int nw, input int bad);
    int b;
    b = 0;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1);
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(img[w][8*i +: 8], (b == bad) ? 1'b0 : 1'b1);
        b++;
      end
    end
    idle(2 * CPB);
  endtask

  task automatic expect_image(input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(32'(4 * i));
      exp_data_q.push_back(img[i]);
    end
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err);
    chk({tag, "_done"},     32'(load_done_out),  32'(done));
    chk({tag, "_core_rst"}, 32'(core_rst_n_out), 32'(done));
    chk({tag, "_err"},      32'(err_out),        32'(err));
    chk({tag, "_pending"},  32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    uart_rx_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we",       32'(imem_we_out),    32'd0);
    chk("rst_core_rst", 32'(core_rst_n_out), 32'd0);
    chk("rst_done",     32'(load_done_out),  32'd0);
    chk("rst_err",      32'(err_out),        32'd0);
    chk("rst_addr",     32'(imem_addr_out),  32'd0);
    chk("rst_din",      imem_din_out,        32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    we_cycles = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
  endtask

  initial begin
    do_reset();
    chk_status("idle_after_reset", 1'b0, 1'b0);

    // Two-word image
    img[0] = 32'h0000_0013;
    img[1] = 32'hDEAD_BEEF;
    exp_write_before_release = 1'b1;
    expect_image(2);
    send_image(32'd2, 2, -1);
    chk_status("two_word", 1'b1, 1'b0);
    chk("two_word_we_cycles", 32'(we_cycles), 32'd2);
    chk("two_word_last_addr", last_addr, 32'h0000_0004);
    chk("two_word_last_data", last_data, 32'hDEAD_BEEF);
    // Bytes after completion are ignored
    send_byte(8'hA5, 1'b1);
    idle(2 * CPB);
    chk("two_word_ignore_we", 32'(we_cycles), 32'd2);
    chk_status("two_word_after", 1'b1, 1'b0);

    // Empty image
    do_reset();
    exp_write_before_release = 1'b0;
    send_image(32'd0, 0, -1);
    chk_status("empty", 1'b1, 1'b0);
    chk("empty_we_cycles", 32'(we_cycles), 32'd0);

    // Overflow: 1025 words into a 4096-byte IMEM
    do_reset();
    send_image(32'd1025, 0, -1);
    chk_status("overflow", 1'b0, 1'b1);
    chk("overflow_we_cycles", 32'(we_cycles), 32'd0);

    // Exactly full IMEM is accepted (header only, then abandoned)
    do_reset();
    send_image(32'd1024, 0, -1);
    chk_status("full_size_hdr", 1'b0, 1'b0);

    // Frame error on the 3rd data byte
    do_reset();
    img[0] = 32'h1122_3344;
    send_image(32'd1, 1, 2);
    chk_status("frame_err", 1'b0, 1'b1);
    chk("frame_err_we_cycles", 32'(we_cycles), 32'd0);

    // Start glitch, then a normal one-word image
    do_reset();
    uart_rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    uart_rx_in = 1'b1;
    idle(3 * CPB);
    img[0] = 32'hCAFE_F00D;
    exp_write_before_release = 1'b1;
    expect_image(1);
    send_image(32'd1, 1, -1);
    chk_status("glitch", 1'b1, 1'b0);
    chk("glitch_we_cycles", 32'(we_cycles), 32'd1);
    chk("glitch_last_addr", last_addr, 32'h0000_0000);
    chk("glitch_last_data", last_data, 32'hCAFE_F00D);

    // Reset after word 0 of a 3-word image, then full resend
    do_reset();
    img[0] = 32'hA0A0_A0A1;
    img[1] = 32'hB1B2_B3B4;
    img[2] = 32'h0C0D_0E0F;
    expect_image(1);
    send_image(32'd3, 1, -1);
    chk("partial_we_cycles", 32'(we_cycles), 32'd1);
    chk_status("partial", 1'b0, 1'b0);
    do_reset();
    expect_image(3);
    send_image(32'd3, 3, -1);
    chk_status("reload", 1'b1, 1'b0);
    chk("reload_we_cycles", 32'(we_cycles), 32'd3);
    chk("reload_last_addr", last_addr, 32'h0000_0008);
    chk("reload_last_data", last_data, 32'h0C0D_0E0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/friscv_uart_loader.md
# friscv_uart_loader

Boot loader that sits upstream of the FPGA wrapper's instruction memory. It receives a program image over a UART line and writes it word by word into the IMEM write port. It holds the FRiscV core in reset until the image is complete. It replaces the static IMEM init file when the FPGA is reprogrammed at run time.

## Interface

Parameters:
- `ARCH`, default 32: data word width; must be 32.
- `IMEM_ADDR_WIDTH`, default 12: byte-address width of IMEM.
- `IMEM_DEPTH_BYTES`, default 4096: IMEM size in bytes.
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4, enforced by an elaboration check.

Ports:
- `clk`, in, 1: system clock (`clk_s` domain of the wrapper).
- `rst_n`, in, 1: reset; asynchronous, active-low. One clock; all state is reset by `rst_n`.
- `uart_rx_in`, in, 1: asynchronous serial input, idle high.
- `imem_addr_out`, out, IMEM_ADDR_WIDTH: IMEM byte address.
- `imem_din_out`, out, ARCH: IMEM write data.
- `imem_we_out`, out, 1: IMEM write enable, one-cycle pulse per word.
- `core_rst_n_out`, out, 1: active-low reset to the core; low until load completes.
- `load_done_out`, out, 1: high once the image is loaded, sticky.
- `err_out`, out, 1: frame error or image overflow, sticky.

## Operation

- **UART framing:** 8N1, LSB first. `uart_rx_in` passes through a 2-flop synchroniser before any use.
- **Receiver:**
  - A low level on the synchronised line in idle starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2. If it is high again, the frame is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT thereafter, then the stop bit.
  - Stop bit = 1 → `byte_valid` pulse for 1 cycle with the byte.
  - Stop bit = 0 → `frame_err` pulse for 1 cycle; no byte is produced.
- **Image protocol:** a 4-byte little-endian word count N, followed by N words of 4 bytes each, little-endian.
- **Loader FSM states:**
  - HDR: collect 4 bytes into N using a 2-bit byte index. After the 4th byte, go to CHK.
  - CHK: N == 0 → DONE. N × 4 > IMEM_DEPTH_BYTES → ERR. Otherwise → DATA with word index k = 0.
  - DATA: assemble 4 bytes into a word. After the 4th byte → WRITE.
  - WRITE: drive `imem_addr_out` = 4k, `imem_din_out` = the word, and `imem_we_out` = 1 for one cycle. Then k++. If k == N → DONE, else → DATA.
  - DONE: `core_rst_n_out` = 1 and `load_done_out` = 1. Any further bytes are ignored.
  - ERR: `err_out` = 1 and `core_rst_n_out` stays 0. Only `rst_n` leaves this state.
- A `frame_err` pulse in HDR, DATA or WRITE → ERR. A `frame_err` in DONE is ignored.
- IMEM addresses always step by 4, starting at byte address 0.

## Timing

- **Reset values:** all outputs 0; FSM in HDR; receiver idle.
- **Sync latency:** the line is 2 cycles late relative to `uart_rx_in`.
- **`byte_valid` timing:** asserted 1 cycle after the mid-stop-bit sample.
- **Write timing:** `imem_we_out` is high in the cycle after the `byte_valid` of a word's 4th byte. Address and data are stable in that same cycle.
- **Release timing:** `core_rst_n_out` and `load_done_out` rise in the cycle after the last write, or 1 cycle after CHK when N == 0. Both are registered and glitch-free.
- **Byte spacing:** the minimum spacing between bytes is 10 × CLKS_PER_BIT cycles. The WRITE state (1 cycle) cannot collide with the next byte.
- **Reset mid-operation:** asserting `rst_n` low mid-frame or mid-image clears all state asynchronously. After release, the loader expects a fresh header. IMEM contents are left as written.

## Structure

- In `friscv_sv_pkg`:
  - typedef `loader_state_t` (HDR, CHK, DATA, WRITE, DONE, ERR);
  - `UART_DATA_BITS = 8`;
  - `LOADER_HDR_BYTES = 4`.
- Sub-module `friscv_uart_rx`: contains the synchroniser, bit counter, baud counter, shift register, and the `byte_valid` / `frame_err` outputs. The loader FSM, word assembly and counters live in the top module.

## Test plan

Benches use CLKS_PER_BIT = 8.

- **Two-word image:** send N = 2, then words 0x00000013 and 0xDEADBEEF. Expect writes (addr 0x000, 0x00000013) and (addr 0x004, 0xDEADBEEF), `we` high exactly 2 cycles total, then `core_rst_n_out` = 1 and `load_done_out` = 1.
- **Empty image:** send N = 0. Expect no write; `core_rst_n_out` rises 1 cycle after CHK.
- **Overflow:** send N = 1025 with depth 4096. Expect ERR, `err_out` = 1, no writes, `core_rst_n_out` = 0.
- **Frame error:** send the 3rd data byte with stop bit = 0. Expect `err_out` = 1, no write for that word, and the core held in reset.
- **Start glitch:** pull the line low for 2 cycles in idle. Expect no `byte_valid`; the following valid image loads normally.
- **Reset mid-load:** assert `rst_n` low after word 0 of a 3-word image, release, then resend the full image. Expect writes restart at addr 0 and done after 3 writes.
